// File: rtl/fpu_ctrl_pkg.sv
// Shared encodings for the FPU fcsr controller: flag positions, rounding modes,
// CSR address/op codes, the CSR sequencing states and the CSR read-modify helper.
package fpu_ctrl_pkg;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100,
        RM_DYN = 3'b111
    } rm_e;

    typedef enum logic [1:0] {
        CSR_FFLAGS = 2'b00,
        CSR_FRM    = 2'b01,
        CSR_FCSR   = 2'b10,
        CSR_RSVD   = 2'b11
    } csr_addr_e;

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_ACCESS = 2'b10,
        ST_RESP   = 2'b11
    } csr_state_e;

    // Bitwise effect of a CSR op on an aligned value; callers mask the result
    // down to the addressed field.
    function automatic logic [7:0] csr_apply(csr_op_e op, logic [7:0] cur, logic [7:0] opnd);
        logic [7:0] res;
        case (op)
            CSR_OP_WRITE: res = opnd;
            CSR_OP_SET:   res = cur | opnd;
            CSR_OP_CLEAR: res = cur & ~opnd;
            default:      res = cur;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/fpu_inflight_counter.sv
// Outstanding-op counter: increments stop at the limit, decrements at zero are
// dropped, simultaneous inc/dec leaves the count unchanged.
module fpu_inflight_counter #(
    parameter int MAX = 4,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         at_limit,
    output logic         is_zero
);

    localparam logic [W-1:0] LIMIT = W'(MAX);

    logic inc_ok, dec_ok;

    assign at_limit = (cnt >= LIMIT);
    assign is_zero  = (cnt == '0);
    assign inc_ok   = inc && !at_limit;
    assign dec_ok   = dec && !is_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (inc_ok && !dec_ok)
            cnt <= cnt + 1'b1;
        else if (dec_ok && !inc_ok)
            cnt <= cnt - 1'b1;
    end

endmodule

// File: rtl/fpu_fcsr_ctrl.sv
// FPU fcsr owner: rounding-mode resolution, sticky flag accumulation and CSR
// accesses serialised behind a pipeline drain. Define FPU_DYN_RM_EN to let rm=111 use frm.
module fpu_fcsr_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    output logic       issue_ready,
    input  logic [2:0] issue_rm,
    output logic [2:0] issue_rm_eff,
    output logic       issue_rm_illegal,
    input  logic       retire_valid,
    input  logic [4:0] retire_flags,
    input  logic       csr_req_valid,
    output logic       csr_req_ready,
    input  logic [1:0] csr_addr,
    input  logic [1:0] csr_op,
    input  logic [7:0] csr_wdata,
    output logic       csr_resp_valid,
    output logic [7:0] csr_rdata,
    output logic [2:0] frm,
    output logic [4:0] fflags,
    output logic [3:0] inflight_cnt
);

    csr_state_e state_q, state_d;
    csr_addr_e  addr_q;
    csr_op_e    op_q;
    logic [7:0] wdata_q;
    logic [2:0] frm_q;
    logic [4:0] fflags_q;
    logic [7:0] rdata_q;

    logic       at_limit, is_zero;
    logic       rm_ill;
    logic [2:0] rm_res;
    logic       issue_acc, retire_ok, req_hs;

    logic [7:0] fcsr_cur, fcsr_new, view, fmask, opnd;

    // Rounding-mode resolution is purely combinational on the current frm.
    always_comb begin
        rm_ill = 1'b0;
        rm_res = issue_rm;
        case (issue_rm)
            3'b101, 3'b110: rm_ill = 1'b1;
            RM_DYN: begin
`ifdef FPU_DYN_RM_EN
                if (frm_q > RM_RMM)
                    rm_ill = 1'b1;
                else
                    rm_res = frm_q;
`else
                rm_ill = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign issue_rm_illegal = rm_ill;
    assign issue_rm_eff     = rm_ill ? 3'b000 : rm_res;

    assign issue_ready    = (state_q == ST_IDLE) && !at_limit;
    assign csr_req_ready  = (state_q == ST_IDLE);
    assign csr_resp_valid = (state_q == ST_RESP);
    assign issue_acc      = issue_valid && issue_ready && !rm_ill;
    assign retire_ok      = retire_valid && !is_zero;
    assign req_hs         = csr_req_valid && csr_req_ready;

    fpu_inflight_counter #(.MAX(MAX_INFLIGHT), .W(4)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (issue_acc),
        .dec      (retire_valid),
        .cnt      (inflight_cnt),
        .at_limit (at_limit),
        .is_zero  (is_zero)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_hs) state_d = ST_DRAIN;
            ST_DRAIN:  if (is_zero) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // The access works on the packed {frm,fflags} image; the mask confines the
    // op to the addressed field and the operand is aligned to that field.
    always_comb begin
        fcsr_cur = {frm_q, fflags_q};
        view     = 8'h00;
        fmask    = 8'h00;
        opnd     = 8'h00;
        case (addr_q)
            CSR_FFLAGS: begin
                view  = {3'b000, fflags_q};
                fmask = 8'h1f;
                opnd  = {3'b000, wdata_q[4:0]};
            end
            CSR_FRM: begin
                view  = {5'b00000, frm_q};
                fmask = 8'he0;
                opnd  = {wdata_q[2:0], 5'b00000};
            end
            CSR_FCSR: begin
                view  = fcsr_cur;
                fmask = 8'hff;
                opnd  = wdata_q;
            end
            default: ;
        endcase
        fcsr_new = (fcsr_cur & ~fmask) | (csr_apply(op_q, fcsr_cur, opnd) & fmask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= CSR_FFLAGS;
            op_q     <= CSR_OP_READ;
            wdata_q  <= 8'h00;
            frm_q    <= 3'b000;
            fflags_q <= 5'b00000;
            rdata_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            if (req_hs) begin
                addr_q  <= csr_addr_e'(csr_addr);
                op_q    <= csr_op_e'(csr_op);
                wdata_q <= csr_wdata;
            end
            // Count is zero in ACCESS, so no retire can be accepted alongside it.
            if (state_q == ST_ACCESS) begin
                rdata_q           <= view;
                {frm_q, fflags_q} <= fcsr_new;
            end else if (retire_ok) begin
                fflags_q <= fflags_q | retire_flags;
            end
        end
    end

    assign frm       = frm_q;
    assign fflags    = fflags_q;
    assign csr_rdata = rdata_q;

endmodule
